// File: rtl/addsub_seq_arbiter_if.sv
// Requester and datapath signal bundle for the nibble-serial add/sub arbiter.
// slave = arbiter side, master = requesters plus the 4-bit add/sub slice.
interface addsub_seq_arbiter_if #(
  parameter int unsigned NIB = 4
);
  localparam int unsigned W = 4 * NIB;

  logic         req0, req1;
  logic         sub0, sub1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1;
  logic         done0, done1;
  logic [W-1:0] result;
  logic         cout, ovf, busy;
  logic [3:0]   dp_a, dp_b;
  logic         dp_cin, dp_s;
  logic [3:0]   dp_sum;
  logic         dp_cout;

  modport slave (
    input  req0, req1, sub0, sub1, a0, b0, a1, b1, dp_sum, dp_cout,
    output gnt0, gnt1, done0, done1, result, cout, ovf, busy,
           dp_a, dp_b, dp_cin, dp_s
  );

  modport master (
    output req0, req1, sub0, sub1, a0, b0, a1, b1, dp_sum, dp_cout,
    input  gnt0, gnt1, done0, done1, result, cout, ovf, busy,
           dp_a, dp_b, dp_cin, dp_s
  );
endinterface

// File: rtl/addsub_seq_arbiter.sv
// Round-robin arbiter sharing one 4-bit add/sub slice between two requesters,
// running W-bit operations one nibble per clock with a chained carry.
module addsub_seq_arbiter #(
  parameter int unsigned NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  addsub_seq_arbiter_if.slave  bus
);
  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned KW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [KW-1:0] r_k;
  logic [W-1:0]  r_a, r_b, r_res_nxt, r_result;
  logic          r_sub, r_carry, r_cout, r_ovf;
  logic          r_owner, r_last;

  logic          w_grant, w_owner, w_last_nib;
  logic [3:0]    w_dp_a, w_dp_b;
  logic          w_dp_cin, w_dp_s;
  logic [W-1:0]  w_final;

  // Partial result shifts right each nibble, so the final value is the
  // current slice output on top of the NIB-1 nibbles already captured.
  assign w_final    = {bus.dp_sum, r_res_nxt[W-1:4]};
  assign w_last_nib = (r_k == KW'(NIB - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_owner     = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
    w_dp_a      = '0;
    w_dp_b      = '0;
    w_dp_cin    = 1'b0;
    w_dp_s      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_grant     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_dp_a   = r_a[{r_k, 2'b00} +: 4];
        w_dp_b   = r_b[{r_k, 2'b00} +: 4];
        w_dp_cin = r_carry;
        w_dp_s   = r_sub;
        if (w_last_nib) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sub     <= 1'b0;
      r_carry   <= 1'b0;
      r_res_nxt <= '0;
      r_result  <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_owner;
            r_a     <= w_owner ? bus.a1 : bus.a0;
            r_b     <= w_owner ? bus.b1 : bus.b0;
            r_sub   <= w_owner ? bus.sub1 : bus.sub0;
            r_carry <= w_owner ? bus.sub1 : bus.sub0;
            r_k     <= '0;
          end
        end
        RUN: begin
          r_res_nxt <= w_final;
          r_carry   <= bus.dp_cout;
          r_k       <= r_k + 1'b1;
          // Result/cout/ovf load on the edge into DONE so they are already
          // valid during the DONE cycle and held until the next one.
          if (w_last_nib) begin
            r_result <= w_final;
            r_cout   <= bus.dp_cout;
            r_ovf    <= (r_a[W-1] == (r_b[W-1] ^ r_sub)) &&
                        (bus.dp_sum[3] != r_a[W-1]);
          end
        end
        DONE:    r_last <= r_owner;
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.gnt0   = (r_state != IDLE) && !r_owner;
  assign bus.gnt1   = (r_state != IDLE) &&  r_owner;
  assign bus.done0  = (r_state == DONE) && !r_owner;
  assign bus.done1  = (r_state == DONE) &&  r_owner;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;
  assign bus.dp_a   = w_dp_a;
  assign bus.dp_b   = w_dp_b;
  assign bus.dp_cin = w_dp_cin;
  assign bus.dp_s   = w_dp_s;
endmodule

// File: tb/tb_addsub_seq_arbiter.sv
// Bench for addsub_seq_arbiter: timeline/arithmetic reference model checked
// every cycle, plus directed cases with literal expectations.
module tb_addsub_seq_arbiter;
  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  addsub_seq_arbiter_if #(.NIB(NIB)) u_if();
  addsub_seq_arbiter #(.NIB(NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  // 4-bit add/sub slice: b is XORed with s inside the slice
  logic [4:0] slice;
  assign slice = {1'b0, u_if.dp_a} + {1'b0, (u_if.dp_b ^ {4{u_if.dp_s}})} + {4'b0, u_if.dp_cin};
  assign u_if.dp_sum  = slice[3:0];
  assign u_if.dp_cout = slice[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [16:0] full_sum(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] bx;
    bx = s ? ~b : b;
    return {1'b0, a} + {1'b0, bx} + {16'b0, s};
  endfunction

  function automatic logic ovf_of(input logic [15:0] a, input logic [15:0] b, input logic s);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = s ? (sa - sb) : (sa + sb);
    return (r > 32767) || (r < -32768);
  endfunction

  function automatic logic cin_of(input logic [15:0] a, input logic [15:0] b, input logic s, input int k);
    logic [31:0] mk, bx, t;
    mk = (32'd1 << (4 * k)) - 32'd1;
    bx = s ? {16'b0, ~b} : {16'b0, b};
    t  = (({16'b0, a} & mk) + (bx & mk) + {31'b0, s}) >> (4 * k);
    return t[0];
  endfunction

  int          m_phase;   // 0 idle, 1..NIB nibble k=phase-1, NIB+1 done
  logic        m_owner, m_last, m_sub, m_cout, m_ovf;
  logic [15:0] m_a, m_b, m_result;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= 0;
      m_owner  <= 1'b0;
      m_last   <= 1'b1;
      m_result <= '0;
      m_cout   <= 1'b0;
      m_ovf    <= 1'b0;
    end else if (m_phase == 0) begin
      if (u_if.req0 || u_if.req1) begin
        logic o;
        o = (u_if.req0 && u_if.req1) ? !m_last : u_if.req1;
        m_owner <= o;
        m_a     <= o ? u_if.a1 : u_if.a0;
        m_b     <= o ? u_if.b1 : u_if.b0;
        m_sub   <= o ? u_if.sub1 : u_if.sub0;
        m_phase <= 1;
      end
    end else if (m_phase == NIB) begin
      logic [16:0] fs;
      fs = full_sum(m_a, m_b, m_sub);
      m_result <= fs[15:0];
      m_cout   <= fs[16];
      m_ovf    <= ovf_of(m_a, m_b, m_sub);
      m_phase  <= NIB + 1;
    end else if (m_phase == NIB + 1) begin
      m_last  <= m_owner;
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit        act, run;
      int        k;
      logic [9:0] exp_dp;
      act = (m_phase != 0);
      run = (m_phase >= 1) && (m_phase <= NIB);
      k   = m_phase - 1;
      chk("handshake",
          32'({u_if.busy, u_if.gnt0, u_if.gnt1, u_if.done0, u_if.done1}),
          32'({act, act && !m_owner, act && m_owner,
               (m_phase == NIB + 1) && !m_owner, (m_phase == NIB + 1) && m_owner}));
      chk("result", 32'({u_if.cout, u_if.ovf, u_if.result}), 32'({m_cout, m_ovf, m_result}));
      exp_dp = '0;
      if (run) exp_dp = {4'((m_a >> (4 * k)) & 16'hF), 4'((m_b >> (4 * k)) & 16'hF),
                         m_sub, cin_of(m_a, m_b, m_sub, k)};
      chk("datapath", 32'({u_if.dp_a, u_if.dp_b, u_if.dp_s, u_if.dp_cin}), 32'(exp_dp));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle();
    int n;
    u_if.req0 = 1'b0;
    u_if.req1 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (u_if.busy && n < 30);
    chk("idle reached", 32'(u_if.busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called in IDLE; drops req and scrambles operands right after the grant
  task automatic run_op(input bit who, input logic [15:0] a, input logic [15:0] b, input bit s,
                        input logic [15:0] er, input bit ec, input bit eo, input string nm);
    int lat, gcnt;
    bit seen;
    if (who) begin u_if.a1 = a; u_if.b1 = b; u_if.sub1 = s; u_if.req1 = 1'b1; end
    else     begin u_if.a0 = a; u_if.b0 = b; u_if.sub0 = s; u_if.req0 = 1'b1; end
    @(posedge clk); #1;
    u_if.req0 = 1'b0;
    u_if.req1 = 1'b0;
    if (who) begin u_if.a1 = 16'($urandom); u_if.b1 = 16'($urandom); u_if.sub1 = ~s; end
    else     begin u_if.a0 = 16'($urandom); u_if.b0 = 16'($urandom); u_if.sub0 = ~s; end
    lat = 0; gcnt = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (who ? u_if.gnt1 : u_if.gnt0) gcnt++;
      if (who ? u_if.done1 : u_if.done0) begin
        seen = 1'b1;
        chk({nm, " result"}, 32'(u_if.result), 32'(er));
        chk({nm, " cout/ovf"}, 32'({u_if.cout, u_if.ovf}), 32'({ec, eo}));
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'd5);
    chk({nm, " gnt cycles"}, 32'(gcnt), 32'd5);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, cyc, ndone, last_cyc, busy_cnt;
    logic [15:0] arb_exp[2];
    u_if.req0 = 0; u_if.req1 = 0; u_if.sub0 = 0; u_if.sub1 = 0;
    u_if.a0 = '0; u_if.b0 = '0; u_if.a1 = '0; u_if.b1 = '0;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("reset ctl", 32'({u_if.gnt0, u_if.gnt1, u_if.done0, u_if.done1, u_if.busy, u_if.cout,
                          u_if.ovf, u_if.dp_s, u_if.dp_cin, u_if.dp_a, u_if.dp_b}), 32'd0);
    chk("reset result", 32'(u_if.result), 32'd0);

    run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "add");
    run_op(1'b1, 16'h0007, 16'h0003, 1'b1, 16'h0004, 1'b1, 1'b0, "sub 7-3");
    run_op(1'b1, 16'h0003, 16'h0007, 1'b1, 16'hFFFC, 1'b0, 1'b0, "sub 3-7");
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "7FFF+1");
    run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "FFFF+1");
    run_op(1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "8000-1");

    busy_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (u_if.busy) busy_cnt++;
    end
    chk("no regrant after release", 32'(busy_cnt), 32'd0);

    // Arbitration: both held from reset -> 0,1,0,1 spaced NIB+2 apart
    do_reset();
    u_if.a0 = 16'h0100; u_if.b0 = 16'h0001; u_if.sub0 = 1'b0;
    u_if.a1 = 16'h0500; u_if.b1 = 16'h0200; u_if.sub1 = 1'b1;
    arb_exp[0] = 16'h0101;
    arb_exp[1] = 16'h0300;
    u_if.req0 = 1'b1; u_if.req1 = 1'b1;
    cyc = 0; ndone = 0; last_cyc = 0;
    while (ndone < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (u_if.done0 || u_if.done1) begin
        chk("arb owner", 32'(u_if.done1), 32'(ndone % 2));
        chk("arb result", 32'(u_if.result), 32'(arb_exp[ndone % 2]));
        if (ndone > 0) chk("arb spacing", 32'(cyc - last_cyc), 32'd6);
        last_cyc = cyc;
        ndone++;
      end
    end
    chk("arb done count", 32'(ndone), 32'd4);
    wait_idle();

    // Reset in the third RUN cycle
    u_if.a0 = 16'h0005; u_if.b0 = 16'h0006; u_if.sub0 = 1'b0; u_if.req0 = 1'b1;
    @(posedge clk); #1 u_if.req0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midop rst ctl", 32'({u_if.gnt0, u_if.gnt1, u_if.done0, u_if.done1, u_if.busy, u_if.cout,
                              u_if.ovf, u_if.dp_s, u_if.dp_cin, u_if.dp_a, u_if.dp_b}), 32'd0);
    chk("midop rst result", 32'(u_if.result), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (u_if.done0 || u_if.done1) n++;
    end
    chk("no done after rst", 32'(n), 32'd0);
    @(posedge clk); #1;
    run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "post-rst add");

    // Random traffic, checked every cycle by the model
    repeat (400) begin
      @(posedge clk); #1;
      u_if.req0 = ($urandom_range(0, 3) != 0);
      u_if.req1 = ($urandom_range(0, 3) != 0);
      u_if.a0 = 16'($urandom); u_if.b0 = 16'($urandom); u_if.sub0 = 1'($urandom);
      u_if.a1 = 16'($urandom); u_if.b1 = 16'($urandom); u_if.sub1 = 1'($urandom);
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
